// File: rtl/dickson_pump_driver.sv
// Two-phase non-overlapping clock generator for the Dickson charge pump.
// Programmable half-period/dead time, optional burst regulation from an async comparator.
module dickson_pump_driver #(
    parameter int DIV_W       = 8,
    parameter int DEAD_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              reg_en,
    input  logic              comp_in,
    input  logic [DIV_W-1:0]  div,
    input  logic [DEAD_W-1:0] dead,
    input  logic              cnt_clr,
    output logic              phi1,
    output logic              phi2,
    output logic              running,
    output logic [CNT_W-1:0]  pulse_cnt
);

    localparam int CW = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    typedef enum logic [2:0] {IDLE, PH1, DEAD1, PH2, DEAD2} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [DIV_W-1:0]       div_q;
    logic [DEAD_W-1:0]      dead_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   comp_sync;
    logic                   demand;
    logic                   ph_last, dead_last, dead_zero;
    logic                   start;

    // comp_in is unrelated to clk; only the last stage is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
    end

    assign comp_sync = sync_q[SYNC_STAGES-1];
    assign demand    = en & (~reg_en | comp_sync);

    // Timing decisions use the values captured at PH1 entry, so a cycle is self-consistent
    assign ph_last   = (cnt == CW'(div_q));
    assign dead_last = (cnt == (CW'(dead_q) - CW'(1)));
    assign dead_zero = (dead_q == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (demand)    state_nx = PH1;
            PH1:     if (ph_last)   state_nx = dead_zero ? PH2 : DEAD1;
            DEAD1:   if (dead_last) state_nx = PH2;
            PH2: begin
                if (ph_last) begin
                    if (!dead_zero) state_nx = DEAD2;
                    else            state_nx = demand ? PH1 : IDLE;
                end
            end
            DEAD2:   if (dead_last) state_nx = demand ? PH1 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign start = (state_nx == PH1) && (state != PH1);

    always_comb begin
        cnt_nx = cnt + CW'(1);
        if ((state_nx != state) || (state == IDLE)) cnt_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= '0;
            dead_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                div_q  <= div;
                dead_q <= dead;
            end
        end
    end

    // Outputs are registered copies of the next state: glitch-free and never overlapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi1    <= 1'b0;
            phi2    <= 1'b0;
            running <= 1'b0;
        end else begin
            phi1    <= (state_nx == PH1);
            phi2    <= (state_nx == PH2);
            running <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          pulse_cnt <= '0;
        else if (cnt_clr)                    pulse_cnt <= '0;
        else if (start && (pulse_cnt != '1)) pulse_cnt <= pulse_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_dickson_pump_driver.sv
// Directed bench for dickson_pump_driver: waveform shape, regulation, disable, reset, counter.
module tb_dickson_pump_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, reg_en = 1'b0, comp_in = 1'b0, cnt_clr = 1'b0;
    logic [7:0]  div = 8'd0;
    logic [3:0]  dead = 4'd0;
    logic        phi1, phi2, running;
    logic [15:0] pulse_cnt;

    // small-counter instance for saturation checks
    logic        en_b = 1'b0, reg_en_b = 1'b0, cnt_clr_b = 1'b0;
    logic [7:0]  div_b = 8'd0;
    logic [3:0]  dead_b = 4'd0;
    logic        phi1_b, phi2_b, running_b;
    logic [3:0]  pulse_cnt_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dickson_pump_driver #(.DIV_W(8), .DEAD_W(4), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .reg_en(reg_en), .comp_in(comp_in),
        .div(div), .dead(dead), .cnt_clr(cnt_clr),
        .phi1(phi1), .phi2(phi2), .running(running), .pulse_cnt(pulse_cnt)
    );

    dickson_pump_driver #(.DIV_W(8), .DEAD_W(4), .SYNC_STAGES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .reg_en(reg_en_b), .comp_in(comp_in),
        .div(div_b), .dead(dead_b), .cnt_clr(cnt_clr_b),
        .phi1(phi1_b), .phi2(phi2_b), .running(running_b), .pulse_cnt(pulse_cnt_b)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // {phi1, phi2, running} at position k of a free-running cycle
    function automatic logic [2:0] exp_ph(int d, int dd, int k);
        int p, m;
        p = 2 * (d + 1) + 2 * dd;
        m = k % p;
        if (m < d + 1)                return 3'b101;
        else if (m < d + 1 + dd)      return 3'b001;
        else if (m < 2 * (d + 1) + dd) return 3'b011;
        else                          return 3'b001;
    endfunction

    task automatic test_reset;
        #3;
        total++;
        if ({phi1, phi2, running} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs got=%b want=000", {phi1, phi2, running});
        end
        total++;
        if (pulse_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d want=0", pulse_cnt);
        end
        total++;
        if (pulse_cnt_b !== 4'd0) begin
            bad++; $display("FAIL reset_cnt_b got=%0d want=0", pulse_cnt_b);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b want=0", running);
        end
    endtask

    task automatic test_free_run;
        logic [2:0] want;
        div = 8'd3; dead = 4'd1; reg_en = 1'b0; en = 1'b1;
        for (int s = 1; s <= 22; s++) begin
            step();
            want = (s <= 20) ? exp_ph(3, 1, s - 1) : 3'b000;
            total++;
            if ({phi1, phi2, running} !== want) begin
                bad++; $display("FAIL free_run s=%0d got=%b want=%b", s, {phi1, phi2, running}, want);
            end
            total++;
            if ((phi1 & phi2) !== 1'b0) begin
                bad++; $display("FAIL free_run_overlap s=%0d got=1 want=0", s);
            end
            if (s == 1 || s == 11 || s == 20) begin
                total++;
                if (pulse_cnt !== ((s == 1) ? 16'd1 : 16'd2)) begin
                    bad++; $display("FAIL free_run_cnt s=%0d got=%0d want=%0d", s, pulse_cnt, (s == 1) ? 1 : 2);
                end
            end
            if (s == 20) en = 1'b0;
        end
    endtask

    task automatic test_zero_dead;
        logic [2:0] want;
        div = 8'd0; dead = 4'd0; en = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            want = (s <= 8) ? exp_ph(0, 0, s - 1) : 3'b000;
            total++;
            if ({phi1, phi2, running} !== want) begin
                bad++; $display("FAIL zero_dead s=%0d got=%b want=%b", s, {phi1, phi2, running}, want);
            end
            total++;
            if ((phi1 & phi2) !== 1'b0) begin
                bad++; $display("FAIL zero_dead_overlap s=%0d got=1 want=0", s);
            end
            if (s == 8) en = 1'b0;
        end
    endtask

    task automatic test_regulation;
        logic [2:0] want;
        div = 8'd2; dead = 4'd1; reg_en = 1'b1; en = 1'b1; comp_in = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        comp_in = 1'b1;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (s < 3)       want = 3'b000;
            else if (s <= 34) want = exp_ph(2, 1, s - 3);
            else             want = 3'b000;
            total++;
            if ({phi1, phi2, running} !== want) begin
                bad++; $display("FAIL regulation s=%0d got=%b want=%b", s, {phi1, phi2, running}, want);
            end
            if (s == 30) comp_in = 1'b0;
        end
        total++;
        if (pulse_cnt !== 16'd4) begin
            bad++; $display("FAIL regulation_cnt got=%0d want=4", pulse_cnt);
        end
        reg_en = 1'b0; en = 1'b0;
    endtask

    task automatic test_disable_mid;
        logic [2:0] want;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        div = 8'd5; dead = 4'd2; en = 1'b1;
        for (int s = 1; s <= 24; s++) begin
            step();
            want = (s <= 16) ? exp_ph(5, 2, s - 1) : 3'b000;
            total++;
            if ({phi1, phi2, running} !== want) begin
                bad++; $display("FAIL disable_mid s=%0d got=%b want=%b", s, {phi1, phi2, running}, want);
            end
            if (s == 2) en = 1'b0;
        end
        total++;
        if (pulse_cnt !== 16'd1) begin
            bad++; $display("FAIL disable_mid_cnt got=%0d want=1", pulse_cnt);
        end
    endtask

    task automatic test_reset_reconfig;
        logic [2:0] want;
        div = 8'd3; dead = 4'd1; en = 1'b1;
        for (int s = 1; s <= 7; s++) step();
        total++;
        if (phi2 !== 1'b1) begin
            bad++; $display("FAIL pre_reset_phi2 got=%b want=1", phi2);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({phi1, phi2, running} !== 3'b000) begin
            bad++; $display("FAIL async_reset_outputs got=%b want=000", {phi1, phi2, running});
        end
        total++;
        if (pulse_cnt !== 16'd0) begin
            bad++; $display("FAIL async_reset_cnt got=%0d want=0", pulse_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 1; s <= 29; s++) begin
            step();
            if (s <= 10)      want = exp_ph(3, 1, s - 1);
            else if (s <= 28) want = exp_ph(7, 1, s - 11);
            else              want = 3'b000;
            total++;
            if ({phi1, phi2, running} !== want) begin
                bad++; $display("FAIL reconfig s=%0d got=%b want=%b", s, {phi1, phi2, running}, want);
            end
            if (s == 1)  div = 8'd7;
            if (s == 20) en = 1'b0;
        end
        total++;
        if (pulse_cnt !== 16'd2) begin
            bad++; $display("FAIL reconfig_cnt got=%0d want=2", pulse_cnt);
        end
    endtask

    task automatic test_counter;
        div_b = 8'd0; dead_b = 4'd0; en_b = 1'b1;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (s == 20) begin
                total++;
                if (pulse_cnt_b !== 4'd10) begin
                    bad++; $display("FAIL counter_mid got=%0d want=10", pulse_cnt_b);
                end
            end
        end
        total++;
        if (pulse_cnt_b !== 4'd15) begin
            bad++; $display("FAIL counter_saturate got=%0d want=15", pulse_cnt_b);
        end
        cnt_clr_b = 1'b1;
        step();
        total++;
        if ({phi1_b, pulse_cnt_b} !== {1'b1, 4'd0}) begin
            bad++; $display("FAIL counter_clr_vs_inc got=phi1:%b cnt:%0d want=phi1:1 cnt:0", phi1_b, pulse_cnt_b);
        end
        cnt_clr_b = 1'b0;
        step();
        step();
        total++;
        if (pulse_cnt_b !== 4'd1) begin
            bad++; $display("FAIL counter_after_clr got=%0d want=1", pulse_cnt_b);
        end
        en_b = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_zero_dead();
        test_regulation();
        test_disable_mid();
        test_reset_reconfig();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dickson_pump_driver.md
Name: dickson_pump_driver

Overview:
- Digital driver for the on-chip Dickson charge pump: generates the two non-overlapping pump clock phases (phi1/phi2) that the pump stages consume.
- Programmable half-period and dead time.
- Optional burst-mode regulation from an asynchronous comparator on the pump output.
- Sits between the tile's digital I/O (config and comparator pin) and the analog pump stage drivers.

Parameters:
- DIV_W, 8, width of the half-period setting `div`.
- DEAD_W, 4, width of the dead-time setting `dead`.
- SYNC_STAGES, 2, flops in the `comp_in` synchronizer (minimum 2).
- CNT_W, 16, width of the pump-cycle counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pump enable (synchronous to clk).
- reg_en  input  1  1 = gate pumping with the comparator; 0 = free-run.
- comp_in  input  1  asynchronous comparator output; 1 = output below target, pumping needed.
- div  input  DIV_W  each phase is high for div+1 clk cycles.
- dead  input  DEAD_W  dead-time clk cycles after each phase (0 allowed).
- cnt_clr  input  1  synchronous clear of `pulse_cnt`.
- phi1  output  1  pump phase 1.
- phi2  output  1  pump phase 2.
- running  output  1  high while a pump cycle is in progress.
- pulse_cnt  output  CNT_W  number of started pump cycles, saturating.

Behaviour:
- Clock/reset: one clock, `clk`. `rst_n` is asynchronous and active-low; all flops reset asynchronously.
- Reset values: phi1=0, phi2=0, running=0, pulse_cnt=0, FSM=IDLE, synchronizer flops=0. Asserting rst_n mid-cycle forces phi1 and phi2 low immediately, without waiting for clk.
- Output timing: phi1, phi2 and running come directly from flops, with no combinational decode on the outputs. This guarantees they are glitch-free.
- Comparator path: comp_sync = comp_in after SYNC_STAGES flops. demand = en & (~reg_en | comp_sync).
- FSM states: IDLE, PH1, DEAD1, PH2, DEAD2.
- Per-cycle latching: div and dead are captured into internal registers on every entry to PH1. Changes made mid-cycle take effect from the next cycle.
- IDLE -> PH1: when demand=1 at a clk edge, phi1 goes high at that same edge, i.e. latency from sampled demand to phi1 is 1 edge.
- PH1 -> DEAD1: phi1 stays high for exactly div+1 cycles. If dead==0, PH1 goes directly to PH2 and phi2 rises on the same edge that phi1 falls.
- DEAD1 -> PH2: both phases low for exactly `dead` cycles.
- PH2 -> DEAD2: phi2 stays high for exactly div+1 cycles. If dead==0, PH2 goes directly to the next-state decision.
- DEAD2 exit: after `dead` cycles, go to PH1 if demand=1, otherwise IDLE.
- Cycle period: 2*(div+1) + 2*dead cycles.
- Cycle completion: a started cycle always completes both phases, for charge balance. Dropping en or demand only prevents the next cycle from starting.
- Invariant: phi1 & phi2 == 0 in every cycle, including at reset and at the dead==0 handoff.
- running: 1 in PH1, DEAD1, PH2 and DEAD2; 0 in IDLE.
- pulse_cnt:
  - Increments by 1 on each entry to PH1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr zeroes the count synchronously.
  - If cnt_clr and an increment occur on the same edge, the result is 0.
- Extremes: div=0 gives 1-cycle phases; div at maximum gives 2^DIV_W-cycle phases. dead at maximum is legal.

Test Plan:
- Free-run: en=1, reg_en=0, div=3, dead=1. Required: phi1 high 4 cycles, 1 low, phi2 high 4 cycles, 1 low; period 10; pulse_cnt increments by 1 per period; phi1&phi2 never both 1.
- Zero dead time: div=0, dead=0. Required: phi1 and phi2 alternate every cycle, complementary, period 2, never overlapping.
- Regulation: reg_en=1, comp_in=1 for 30 cycles then 0, with div=2, dead=1. Required: cycles run while comp_sync=1; the cycle in progress when comp_sync falls completes, then IDLE with running=0; first phi1 appears SYNC_STAGES+1 edges after comp_in rises from IDLE.
- Disable mid-phase: en dropped in the 2nd cycle of PH1 with div=5, dead=2. Required: remaining PH1 cycles, 2 dead cycles and 6 PH2 cycles all complete, then IDLE with no further phi1.
- Reset and reconfigure: assert rst_n low mid-PH2. Required: phi2=0 and pulse_cnt=0 without a clk edge. Change div from 3 to 7 during PH1. Required: the current phase stays 4 cycles; the next phi1 lasts 8 cycles.
- Counter: CNT_W=4, free-run for 20 cycles. Required: pulse_cnt holds at 15. cnt_clr on the same edge as an increment. Required: 0.
